tap_bram_arbiter: RTL

- Single-port arbiter in front of the tap coefficient BRAM.
- Shares the BRAM between two requesters:
  - the AXI4-Lite BRAM slave path, which sends tap read/write requests and consumes the arbit arready/rvalid/awready/wready handshakes;
  - the FIR core datapath, which reads taps during filtering.
- The core has fixed priority. A starvation counter guarantees AXI progress.
- Owns the BRAM EN/WE/A/Di pins and the read-valid timing for both requesters.

---
 rtl/tap_bram_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tap_bram_arbiter.sv
// Single-port arbiter for the tap coefficient BRAM, shared by the AXI-Lite slave path and the FIR core.
// The core has fixed priority, and a bounded starvation counter guarantees AXI progress.
module tap_bram_arbiter #(
  parameter int pDATA_WIDTH   = 32,
  parameter int TAP_NUM_WIDTH = 10,
  parameter int MAX_WAIT      = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       in_axi_rreq,
  input  logic                       in_axi_wreq,
  input  logic [TAP_NUM_WIDTH-1:0]   in_axi_A,
  input  logic [pDATA_WIDTH-1:0]     in_axi_Di,
  input  logic [pDATA_WIDTH/8-1:0]   in_axi_WE,
  output logic                       out_arbit_arready,
  output logic                       out_arbit_rvalid,
  output logic                       out_arbit_awready,
  output logic                       out_arbit_wready,
  input  logic                       in_core_req,
  input  logic [TAP_NUM_WIDTH-1:0]   in_core_A,
  output logic                       out_core_gnt,
  output logic                       out_core_rvalid,
  output logic                       out_bram_EN,
  output logic [pDATA_WIDTH/8-1:0]   out_bram_WE,
  output logic [TAP_NUM_WIDTH-1:0]   out_bram_A,
  output logic [pDATA_WIDTH-1:0]     out_bram_Di,
  input  logic [pDATA_WIDTH-1:0]     in_bram_Do,
  output logic [pDATA_WIDTH-1:0]     out_tap_Do,
  output logic [1:0]                 out_dbg_rd_owner,
  output logic [3:0]                 out_dbg_starve_cnt
);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_AXI  = 2'd1,
    RD_CORE = 2'd2
  } rd_owner_e;

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  rd_owner_e                  rd_owner_q, rd_owner_d;
  logic [3:0]                 starve_q, starve_d;
  logic [TAP_NUM_WIDTH-1:0]   a_q, a_d;
  logic [pDATA_WIDTH-1:0]     di_q, di_d;

  logic axi_pend, force_axi;
  logic gnt_core, gnt_wr, gnt_rd;

  // Handshake: a request is held until its grant; the grant and the BRAM access
  // happen in the same cycle, and read data is valid for exactly one cycle, one
  // cycle after the grant. rvalid never waits for a consumer.
  assign axi_pend  = in_axi_rreq | in_axi_wreq;
  assign force_axi = axi_pend && (starve_q == MAX_W);

  always_comb begin
    gnt_core = 1'b0;
    gnt_wr   = 1'b0;
    gnt_rd   = 1'b0;
    if (!areset) begin
      if (force_axi) begin
        gnt_wr = in_axi_wreq;
        gnt_rd = ~in_axi_wreq;
      end else if (in_core_req) begin
        gnt_core = 1'b1;
      end else if (in_axi_wreq) begin
        gnt_wr = 1'b1;
      end else if (in_axi_rreq) begin
        gnt_rd = 1'b1;
      end
    end
  end

  always_comb begin
    rd_owner_d = RD_NONE;
    if (gnt_rd) begin
      rd_owner_d = RD_AXI;
    end else if (gnt_core) begin
      rd_owner_d = RD_CORE;
    end

    starve_d = starve_q;
    if (!axi_pend || gnt_wr || gnt_rd) begin
      starve_d = 4'd0;
    end else if (gnt_core && (starve_q < MAX_W)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Address and write data keep their last driven value while the BRAM is idle.
  always_comb begin
    out_bram_EN = gnt_core | gnt_wr | gnt_rd;
    out_bram_WE = gnt_wr ? in_axi_WE : '0;
    out_bram_A  = a_q;
    out_bram_Di = di_q;
    if (gnt_core) begin
      out_bram_A = in_core_A;
    end else if (gnt_wr || gnt_rd) begin
      out_bram_A = in_axi_A;
    end
    if (gnt_wr) begin
      out_bram_Di = in_axi_Di;
    end
    a_d  = out_bram_A;
    di_d = out_bram_Di;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_owner_q <= RD_NONE;
      starve_q   <= 4'd0;
      a_q        <= '0;
      di_q       <= '0;
    end else begin
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
      a_q        <= a_d;
      di_q       <= di_d;
    end
  end

  // rvalid is gated by reset so a read in flight is dropped in the reset cycle.
  assign out_arbit_rvalid   = (rd_owner_q == RD_AXI) && !areset;
  assign out_core_rvalid    = (rd_owner_q == RD_CORE) && !areset;
  assign out_arbit_arready  = gnt_rd;
  assign out_arbit_awready  = gnt_wr;
  assign out_arbit_wready   = gnt_wr;
  assign out_core_gnt       = gnt_core;
  assign out_tap_Do         = in_bram_Do;
  assign out_dbg_rd_owner   = rd_owner_q;
  assign out_dbg_starve_cnt = starve_q;

endmodule
